// File: rtl/maze_packet_rx.sv
// maze_packet_rx: receiver for the 3-wire link that carries 16-bit maze-cell update words.
// It synchronises the link, shifts the word in MSB first, then validates it and emits it or counts a rejected frame.
module maze_packet_rx #(
  parameter int SYNC_STAGES    = 2,
  parameter int MAX_X          = 4,
  parameter int MAX_Y          = 3,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        SPI_SS_N,
  output logic [15:0] DATA_OUT,
  output logic        DATA_VAL,
  output logic        FRAME_ERR,
  output logic [7:0]  ERR_COUNT
);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]    X_LIM   = 3'(MAX_X);
  localparam logic [1:0]    Y_LIM   = 2'(MAX_Y);

  typedef enum logic [1:0] {IDLE, SHIFT, CHECK, WAIT_SS} state_t;
  state_t state_q, state_d;

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, ss_sync_q;
  logic                   sck_prev_q, ss_prev_q;
  logic [SYNC_STAGES:0]   fill_q;
  logic [15:0]            sr_q, sr_d, data_q, data_d;
  logic [4:0]             bcnt_q, bcnt_d;
  logic [TW-1:0]          to_q, to_d;
  logic                   dval_q, dval_d, ferr_q, ferr_d;
  logic [7:0]             ecnt_q, ecnt_d;
  logic                   sck_s, mosi_s, ss_n_s, sck_rise, ss_fall, ss_rise, ready, reject;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign ss_n_s   = ss_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign ss_fall  = ss_prev_q & ~ss_n_s;
  assign ss_rise  = ~ss_prev_q & ss_n_s;
  // The chains start at idle values, so the first real SS_N level reaches the edge detector
  // only after SYNC_STAGES+1 clocks. Until then a "fall" is only the reset value flushing out.
  assign ready    = fill_q[SYNC_STAGES];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      ss_sync_q   <= '1;
      sck_prev_q  <= 1'b0;
      ss_prev_q   <= 1'b1;
      fill_q      <= '0;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], SPI_SS_N};
      sck_prev_q  <= sck_s;
      ss_prev_q   <= ss_n_s;
      fill_q      <= {fill_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      sr_q    <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
      to_q    <= '0;
      dval_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ecnt_q  <= '0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
      to_q    <= to_d;
      dval_q  <= dval_d;
      ferr_q  <= ferr_d;
      ecnt_q  <= ecnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    to_d    = to_q;
    dval_d  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      IDLE: if (ready) begin
        if (ss_fall) begin
          state_d = SHIFT;
          bcnt_d  = '0;
          to_d    = '0;
        end else if (!ss_n_s) begin
          state_d = WAIT_SS;
        end
      end
      SHIFT: begin
        if (sck_rise) begin
          sr_d   = {sr_q[14:0], mosi_s};
          bcnt_d = (bcnt_q == 5'd17) ? bcnt_q : bcnt_q + 5'd1;
          to_d   = '0;
        end else begin
          to_d = to_q + TW'(1);
        end
        // A closing SS edge wins over a timeout landing on the same cycle.
        if (ss_rise) begin
          state_d = CHECK;
        end else if (!sck_rise && to_q == TO_LAST) begin
          reject  = 1'b1;
          state_d = WAIT_SS;
        end
      end
      CHECK: begin
        if (bcnt_q == 5'd16 && sr_q[15:13] <= X_LIM && sr_q[12:11] <= Y_LIM) begin
          data_d = sr_q;
          dval_d = 1'b1;
        end else begin
          reject = 1'b1;
        end
        state_d = IDLE;
      end
      WAIT_SS: if (ss_n_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ferr_d = reject;
    ecnt_d = (reject && ecnt_q != 8'hFF) ? ecnt_q + 8'd1 : ecnt_q;
  end

  assign DATA_OUT  = data_q;
  assign DATA_VAL  = dval_q;
  assign FRAME_ERR = ferr_q;
  assign ERR_COUNT = ecnt_q;
endmodule

// File: tb/tb_maze_packet_rx.sv
// Directed bench for maze_packet_rx: a frame-level model predicts each outcome and when it appears,
// and a per-cycle monitor compares the DUT against that model.
module tb_maze_packet_rx;
  localparam int S    = 2;
  localparam int TO   = 200;
  localparam int HALF = 3;

  logic        CLK = 1'b0, RESET = 1'b1, SPI_SCK = 1'b0, SPI_MOSI = 1'b0, SPI_SS_N = 1'b1;
  logic [15:0] DATA_OUT;
  logic        DATA_VAL, FRAME_ERR;
  logic [7:0]  ERR_COUNT;

  int errors = 0, checks = 0, cyc = 0, last_rise = 0;

  typedef struct { bit acc; logic [15:0] w; int lo; int hi; } ev_t;
  ev_t evq[$];
  logic [15:0] m_data = '0;
  int          m_err = 0;

  maze_packet_rx #(.SYNC_STAGES(S), .MAX_X(4), .MAX_Y(3), .TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET(RESET), .SPI_SCK(SPI_SCK), .SPI_MOSI(SPI_MOSI), .SPI_SS_N(SPI_SS_N),
    .DATA_OUT(DATA_OUT), .DATA_VAL(DATA_VAL), .FRAME_ERR(FRAME_ERR), .ERR_COUNT(ERR_COUNT)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic void apply(input ev_t e);
    if (e.acc) m_data = e.w;
    else if (m_err < 255) m_err++;
  endfunction

  always @(negedge CLK) begin
    if (RESET) begin
      m_data = '0;
      m_err  = 0;
      evq.delete();
      chk("reset_outputs", {DATA_OUT, DATA_VAL, FRAME_ERR, 6'd0, ERR_COUNT}, 32'd0);
    end else begin
      if (DATA_VAL || FRAME_ERR) begin
        if (evq.size() == 0 || cyc < evq[0].lo) begin
          chk("unexpected_pulse", {30'd0, DATA_VAL, FRAME_ERR}, 32'd0);
        end else begin
          chk("pulse_kind", {30'd0, DATA_VAL, FRAME_ERR}, evq[0].acc ? 32'd2 : 32'd1);
          apply(evq.pop_front());
        end
      end else if (evq.size() > 0 && cyc >= evq[0].hi) begin
        chk("missing_pulse", {30'd0, DATA_VAL, FRAME_ERR}, evq[0].acc ? 32'd2 : 32'd1);
        apply(evq.pop_front());
      end
      chk("data_out", {16'd0, DATA_OUT}, {16'd0, m_data});
      chk("err_count", {24'd0, ERR_COUNT}, m_err);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #2;
  endtask

  task automatic clk_bit(input logic b);
    SPI_MOSI = b;
    tick(HALF);
    SPI_SCK   = 1'b1;
    last_rise = cyc;
    tick(HALF);
    SPI_SCK = 1'b0;
  endtask

  // Model: a 16-bit frame with x <= 4 and y <= 3 is accepted, anything else rejected;
  // the result shows up S+2 clocks after the SS_N rise is driven (sync stages, CHECK, output register).
  task automatic send_frame(input logic [31:0] bits, input int n, input bit coincide);
    ev_t e;
    int  c;
    SPI_SS_N = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      SPI_MOSI = bits[i];
      tick(HALF);
      SPI_SCK = 1'b1;
      if (i == 0 && coincide) SPI_SS_N = 1'b1;
      c = cyc;
      tick(HALF);
      SPI_SCK = 1'b0;
    end
    if (!coincide) begin
      tick(HALF);
      SPI_SS_N = 1'b1;
      c = cyc;
    end
    e.acc = (n == 16) && (bits[15:13] <= 3'd4) && (bits[12:11] <= 2'd3);
    e.w   = bits[15:0];
    e.lo  = c + S + 2;
    e.hi  = c + S + 2;
    evq.push_back(e);
    tick(8);
  endtask

  initial begin
    ev_t  e;
    logic [15:0] w;
    tick(3);
    RESET = 1'b0;
    tick(5);
    chk("post_reset_data", {16'd0, DATA_OUT}, 32'h0);
    chk("post_reset_errcnt", {24'd0, ERR_COUNT}, 32'd0);

    send_frame(32'h8805, 16, 1'b0);
    chk("t1_data", {16'd0, DATA_OUT}, 32'h8805);
    chk("t1_errcnt", {24'd0, ERR_COUNT}, 32'd0);

    send_frame(32'hA001, 16, 1'b0);
    chk("t2_errcnt", {24'd0, ERR_COUNT}, 32'd1);
    chk("t2_data_held", {16'd0, DATA_OUT}, 32'h8805);

    send_frame(32'h7FFF, 15, 1'b0);
    send_frame(32'h1_8805, 17, 1'b0);
    chk("t3_errcnt", {24'd0, ERR_COUNT}, 32'd3);
    chk("t3_data_held", {16'd0, DATA_OUT}, 32'h8805);

    // Timeout: 8 bits, then silence with SS_N held low.
    SPI_SS_N = 1'b0;
    tick(4);
    w = 16'h00A5;
    for (int i = 7; i >= 0; i--) clk_bit(w[i]);
    e.acc = 1'b0;
    e.w   = '0;
    e.lo  = last_rise + S + TO - 1;
    e.hi  = last_rise + S + TO + 3;
    evq.push_back(e);
    tick(TO + 20);
    chk("t4_timeout_errcnt", {24'd0, ERR_COUNT}, 32'd4);
    for (int i = 0; i < 5; i++) clk_bit(1'b1);
    tick(4);
    SPI_SS_N = 1'b1;
    tick(8);
    chk("t4_ignored_errcnt", {24'd0, ERR_COUNT}, 32'd4);
    send_frame(32'h0002, 16, 1'b0);
    chk("t4_data", {16'd0, DATA_OUT}, 32'h0002);

    // Reset in the middle of a frame, released while SS_N is still low.
    w = 16'h6804;
    SPI_SS_N = 1'b0;
    tick(4);
    for (int i = 15; i >= 7; i--) clk_bit(w[i]);
    RESET = 1'b1;
    tick(3);
    RESET = 1'b0;
    for (int i = 6; i >= 0; i--) clk_bit(w[i]);
    tick(HALF);
    SPI_SS_N = 1'b1;
    tick(8);
    chk("t5_errcnt", {24'd0, ERR_COUNT}, 32'd0);
    chk("t5_data_cleared", {16'd0, DATA_OUT}, 32'h0);
    send_frame(32'h4403, 16, 1'b0);
    chk("t5_data", {16'd0, DATA_OUT}, 32'h4403);

    send_frame(32'h6804, 16, 1'b1);
    chk("t6_coincident_data", {16'd0, DATA_OUT}, 32'h6804);
    send_frame(32'h8F05, 16, 1'b0);
    chk("reserved_ignored", {16'd0, DATA_OUT}, 32'h8F05);
    chk("errcnt_before_sat", {24'd0, ERR_COUNT}, 32'd0);

    for (int k = 0; k < 300; k++) send_frame(32'h1, 1, 1'b0);
    chk("errcnt_saturated", {24'd0, ERR_COUNT}, 32'd255);
    chk("sat_data_held", {16'd0, DATA_OUT}, 32'h8F05);

    for (int k = 0; k < 50 && evq.size() > 0; k++) tick(1);
    if (evq.size() > 0) chk("drain_events", evq.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
